register_scan_reader: RTL and testbench

- Read-side companion to the 8-bit write-enabled register bank.
- On a start pulse, walks addresses 0..NREG-1 of the bank's read port and captures each 8-bit value.
- Presents each value to the monitor as an {address, data} word on a valid/ready handshake.
- Sits between the register bank and the debug-monitor transmitter.

---
 rtl/register_scan_reader.sv | 166 ++++++++++++++++
 tb/tb_register_scan_reader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_scan_reader.sv
// -----------------------------------------------------------------------------
// register_scan_reader
//
// Read-side companion to the 8-bit register bank. A start pulse walks the
// bank's read port over addresses 0..NREG-1, captures each value and offers it
// to the debug-monitor transmitter as an {address, data} word on a valid/ready
// handshake. One pass ends with a single-cycle done pulse.
//
// Optional build macro: REGISTER_SCAN_CONTINUOUS_EN
//   When defined, start held high in FINISH chains straight into the next pass
//   (done still pulses) without an IDLE cycle in between.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   begin a scan pass (sampled in IDLE)
//   rd_addr    out  read address to the register bank
//   rd_data    in   bank read data, valid the cycle after rd_addr changes
//   out_valid  out  out_addr/out_data hold a captured word
//   out_ready  in   monitor accepts the word
//   out_addr   out  address of the captured word
//   out_data   out  captured register value
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module register_scan_reader #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [7:0]        out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d = ADDR_ZERO;
                    state_d   = S_SETUP;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            // rd_addr changed on the edge into this state; give the bank's
            // combinational read one full cycle to settle before sampling.
            S_SETUP: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                out_data_d  = rd_data;
                out_addr_d  = rd_addr_q;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end

            // The captured word is held in registers, so later bank changes
            // cannot disturb it while the monitor stalls.
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_addr_q == LAST_ADDR) begin
                        // done is registered, so raise it on the way into
                        // FINISH to make it visible during the FINISH cycle.
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                        state_d   = S_SETUP;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end

            S_FINISH: begin
                rd_addr_d = ADDR_ZERO;
`ifdef REGISTER_SCAN_CONTINUOUS_EN
                if (start) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end

            default: begin
                state_d     = S_IDLE;
                rd_addr_d   = ADDR_ZERO;
                out_valid_d = 1'b0;
            end
        endcase

        // busy is registered, so derive it from the state being entered.
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= ADDR_ZERO;
            out_addr_q  <= ADDR_ZERO;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_register_scan_reader.sv
// -----------------------------------------------------------------------------
// Testbench for register_scan_reader. A behavioural register bank drives
// rd_data; a negedge monitor logs accepted words, done pulses and out_valid
// rising edges. Expected word lists come from a snapshot of the bank contents.
// -----------------------------------------------------------------------------
module tb_register_scan_reader;

    localparam int NREG   = 8;
    localparam int ADDR_W = 3;
`ifdef REGISTER_SCAN_CONTINUOUS_EN
    localparam int PASS_GAP = 25;
    localparam int IDLE_GAP = 0;
`else
    localparam int PASS_GAP = 26;
    localparam int IDLE_GAP = 1;
`endif

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [7:0]        out_data;
    logic              busy;
    logic              done;

    logic [7:0]        bank [NREG];
    logic [ADDR_W+7:0] exp_w [NREG];

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    bit rand_ready = 1'b0;

    logic [ADDR_W+7:0] word_q [$];
    int                done_q [$];
    int                vrise_q [$];
    logic              prev_valid = 1'b0;

    register_scan_reader #(.NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data = bank[rd_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Monitor on the inactive edge: inputs are stable until the next posedge.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) word_q.push_back({out_addr, out_data});
            if (done) done_q.push_back(cycle_cnt);
            if (out_valid && !prev_valid) vrise_q.push_back(cycle_cnt);
            prev_valid <= out_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        word_q.delete();
        done_q.delete();
        vrise_q.delete();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NREG; i++) bank[i] = 8'(8'h10 + i);
    endtask

    task automatic load_random();
        for (int i = 0; i < NREG; i++) bank[i] = 8'($urandom_range(0, 255));
    endtask

    // Expected pass: every address once, in order, with its current bank value.
    task automatic snapshot();
        for (int i = 0; i < NREG; i++) exp_w[i] = {ADDR_W'(i), bank[i]};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; rand_ready = 1'b0;
        tick(); tick();
        checks++; if (rd_addr !== 3'd0)    begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 3'd0)   begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL idle_no_start_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_pass();
        bit ok;
        int t0;
        load_ramp(); snapshot(); clear_mon();
        rand_ready = 1'b0; out_ready = 1'b1;
        t0 = cycle_cnt;
        pulse_start();
        wait_idle(60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout: got busy=%b expected 0", busy); end
        checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL full_count: got %0d expected %0d", word_q.size(), NREG); end
        for (int i = 0; i < NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL full_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i]); end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_q.size()); end
        if (done_q.size() > 0) begin
            checks++; if (done_q[0] - t0 != 3 * NREG + 1) begin errors++; $display("FAIL full_done_latency: got %0d expected %0d", done_q[0] - t0, 3 * NREG + 1); end
        end
        if (vrise_q.size() > 0) begin
            checks++; if (vrise_q[0] - t0 != 3) begin errors++; $display("FAIL first_valid_latency: got %0d expected 3", vrise_q[0] - t0); end
        end
        for (int j = 1; j < vrise_q.size(); j++) begin
            checks++; if (vrise_q[j] - vrise_q[j-1] != 3) begin errors++; $display("FAIL valid_spacing[%0d]: got %0d expected 3", j, vrise_q[j] - vrise_q[j-1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        load_ramp(); snapshot(); clear_mon();
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_addr == 3'd2) begin found = 1'b1; break; end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bp_reach_word2: got %b expected 1", found); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 3) bank[2] = 8'hAA;
            checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_addr !== 3'd2)   begin errors++; $display("FAIL bp_addr[%0d]: got %0d expected 2", k, out_addr); end
            checks++; if (out_data !== 8'h12)  begin errors++; $display("FAIL bp_data[%0d]: got %h expected 12", k, out_data); end
        end
        out_ready = 1'b1;
        wait_idle(60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got busy=%b expected 0", busy); end
        checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL bp_count: got %0d expected %0d", word_q.size(), NREG); end
        for (int i = 0; i < NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i]); end
        end
        bank[2] = 8'h12;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        bit found;
        load_random(); snapshot(); clear_mon();
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_addr == 3'd3) begin found = 1'b1; break; end
            tick();
        end
        out_ready = 1'b0;
        tick(); tick();
        checks++; if (found !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_send: got found=%b valid=%b expected 1 1", found, out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", out_data); end
        checks++; if (rd_addr !== 3'd0)   begin errors++; $display("FAIL rst_mid_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (out_addr !== 3'd0)  begin errors++; $display("FAIL rst_mid_out_addr: got %0d expected 0", out_addr); end
        #1 reset = 1'b0;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        wait_idle(60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_rescan_timeout: got busy=%b expected 0", busy); end
        checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL rst_rescan_count: got %0d expected %0d", word_q.size(), NREG); end
        for (int i = 0; i < NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL rst_rescan_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_start_during_busy();
        bit ok;
        bit found;
        load_random(); snapshot(); clear_mon();
        rand_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (rd_addr == 3'd5) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL busy_reach_addr5: got %b expected 1", found); end
        pulse_start();
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_timeout: got busy=%b expected 0", busy); end
        repeat (30) tick();
        rand_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b expected 0", busy); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_q.size()); end
        checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL busy_count: got %0d expected %0d", word_q.size(), NREG); end
        for (int i = 0; i < NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL busy_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_between_passes();
        bit ok;
        load_ramp(); clear_mon();
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_start();
        wait_idle(60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL between_timeout: got busy=%b expected 0", busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_data !== 8'h17 || out_addr !== 3'd7) begin errors++; $display("FAIL between_hold[%0d]: got %0d/%h expected 7/17", k, out_addr, out_data); end
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL between_idle[%0d]: got valid=%b busy=%b expected 0 0", k, out_valid, busy); end
        end
        bank[0] = 8'h5A;
        snapshot(); clear_mon();
        pulse_start();
        wait_idle(60, ok);
        checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL second_count: got %0d expected %0d", word_q.size(), NREG); end
        for (int i = 0; i < NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL second_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_random_passes();
        bit ok;
        for (int p = 0; p < 5; p++) begin
            load_random(); snapshot(); clear_mon();
            rand_ready = 1'b1;
            pulse_start();
            wait_idle(500, ok);
            rand_ready = 1'b0;
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand%0d_timeout: got busy=%b expected 0", p, busy); end
            checks++; if (done_q.size() != 1) begin errors++; $display("FAIL rand%0d_done: got %0d expected 1", p, done_q.size()); end
            checks++; if (word_q.size() != NREG) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", p, word_q.size(), NREG); end
            for (int i = 0; i < NREG && i < word_q.size(); i++) begin
                checks++; if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL rand%0d_word[%0d]: got %h expected %h", p, i, word_q[i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_continuous();
        int idle_seen;
        int dones;
        load_random(); snapshot(); clear_mon();
        rand_ready = 1'b0; out_ready = 1'b1;
        idle_seen = 0; dones = 0;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (!busy) idle_seen++;
            if (done) begin
                dones++;
                if (dones == 3) break;
            end
        end
        start = 1'b0;
        checks++; if (dones != 3) begin errors++; $display("FAIL cont_dones_seen: got %0d expected 3", dones); end
        checks++; if (idle_seen != 2 * IDLE_GAP) begin errors++; $display("FAIL cont_idle_cycles: got %0d expected %0d", idle_seen, 2 * IDLE_GAP); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b expected 0", busy); end
        repeat (10) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stays_idle: got %b expected 0", busy); end
        checks++; if (done_q.size() != 3) begin errors++; $display("FAIL cont_done_count: got %0d expected 3", done_q.size()); end
        for (int j = 1; j < done_q.size(); j++) begin
            checks++; if (done_q[j] - done_q[j-1] != PASS_GAP) begin errors++; $display("FAIL cont_done_gap[%0d]: got %0d expected %0d", j, done_q[j] - done_q[j-1], PASS_GAP); end
        end
        checks++; if (word_q.size() != 3 * NREG) begin errors++; $display("FAIL cont_count: got %0d expected %0d", word_q.size(), 3 * NREG); end
        for (int i = 0; i < 3 * NREG && i < word_q.size(); i++) begin
            checks++; if (word_q[i] !== exp_w[i % NREG]) begin errors++; $display("FAIL cont_word[%0d]: got %h expected %h", i, word_q[i], exp_w[i % NREG]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_backpressure();
        test_reset_mid_send();
        test_start_during_busy();
        test_between_passes();
        test_random_passes();
        test_continuous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
